// File: rtl/gbuf_arbiter.sv
// gbuf_arbiter: round-robin burst arbiter sharing the single-port global buffer
module gbuf_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*LEN_W-1:0]  len,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    mem_ce,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  state_t              r_state, w_next;
  logic [IW-1:0]       r_rr_ptr, r_owner, r_beat_owner, r_tag_owner, w_pick, w_idx;
  logic                w_found, w_grant, w_last, r_we, r_tag_v;
  logic [ADDR_W-1:0]   r_addr_ptr;
  logic [LEN_W-1:0]    r_count;
  logic [N_REQ-1:0]    r_done;
  assign w_grant = (r_state == IDLE) && w_found;
  assign w_last  = (r_state == BURST) && (r_count == '0);
  assign done    = r_done;
  assign rdata   = mem_rdata;
  // first requester at or after the round-robin pointer, wrapping around
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: grant opens a burst, the beat with count==0 closes it
  always_comb w_next = w_grant ? BURST : w_last ? IDLE : r_state;
  // outputs decoded from state: owner ack and busy
  always_comb begin
    ack = '0;
    if (r_state == BURST) ack[r_owner] = 1'b1;
    busy = (r_state == BURST);
  end
  // grant capture, then address/count stepping once per beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_addr_ptr <= '0;
      r_count    <= '0;
    end else if (w_grant) begin
      r_owner    <= w_pick;
      r_we       <= we[w_pick];
      r_addr_ptr <= addr[int'(w_pick)*ADDR_W +: ADDR_W];
      r_count    <= len[int'(w_pick)*LEN_W +: LEN_W];
      r_rr_ptr   <= (w_pick == IW'(N_REQ - 1)) ? '0 : w_pick + IW'(1);
    end else if (busy) begin
      r_addr_ptr <= r_addr_ptr + ADDR_W'(1);
      r_count    <= r_count - LEN_W'(1);
    end
  // registered buffer strobes; address and data hold while idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_ce       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      r_beat_owner <= '0;
      r_done       <= '0;
    end else begin
      mem_ce <= busy;
      mem_we <= busy & r_we;
      if (busy) begin
        mem_addr     <= r_addr_ptr;
        mem_wdata    <= wdata[int'(r_owner)*DATA_W +: DATA_W];
        r_beat_owner <= r_owner;
      end
      r_done <= w_last ? (N_REQ'(1) << r_owner) : '0;
    end
  // read tag follows each read beat into the buffer's data-return cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tag_v     <= 1'b0;
      r_tag_owner <= '0;
    end else begin
      r_tag_v     <= mem_ce & ~mem_we;
      r_tag_owner <= r_beat_owner;
    end
  // read data strobe steered to the requester that issued the beat
  always_comb begin
    rvalid = '0;
    if (r_tag_v) rvalid[r_tag_owner] = 1'b1;
  end
endmodule
